// File: rtl/siso.sv
// Serial-in/serial-out shift register: a DEPTH-stage delay line for a 1-bit stream.
// sout is the last flop, so every input bit reappears exactly DEPTH clocks later.
module siso #(
  parameter int   DEPTH   = 4,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sin,
  output logic sout
);

  logic [DEPTH-1:0] r_stage;

  // Stage 0 captures sin; every other stage takes its predecessor. Reset clears the whole line at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= {DEPTH{RST_VAL}};
    end else begin
      r_stage[0] <= sin;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign sout = r_stage[DEPTH-1];

endmodule

// File: tb/tb_siso.sv
// Directed self-checking bench for siso, run with DEPTH = 1, 4 and 8 side by side.
module tb_siso;

  logic clk = 1'b0;
  logic rst;
  logic sin;
  logic sout1, sout4, sout8;

  int checks = 0;
  int errors = 0;

  logic stim [1:32];

  siso #(.DEPTH(1), .RST_VAL(1'b0)) u_d1 (.clk(clk), .rst(rst), .sin(sin), .sout(sout1));
  siso #(.DEPTH(4), .RST_VAL(1'b0)) u_d4 (.clk(clk), .rst(rst), .sin(sin), .sout(sout4));
  siso #(.DEPTH(8), .RST_VAL(1'b0)) u_d8 (.clk(clk), .rst(rst), .sin(sin), .sout(sout8));

  always #5 clk = ~clk;

  // Expected output of a depth-d line after the k-th edge since reset release, given stim[].
  function automatic logic exp_at(input int d, input int k);
    if (k >= d) return stim[k-d+1];
    else        return 1'b0;
  endfunction

  function automatic logic pick(input int j);
    case (j)
      0:       return sout1;
      1:       return sout4;
      default: return sout8;
    endcase
  endfunction

  function automatic int depth_of(input int j);
    case (j)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  // Holds rst across one rising edge and releases it on a falling edge.
  task automatic apply_reset();
    rst = 1'b1;
    sin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sin = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (pick(j) !== 1'b0) begin
        errors++;
        $display("FAIL reset_immediate d%0d: got %b want 0", depth_of(j), pick(j));
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sin = (c == 3) ? 1'bx : ~sin;
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (pick(j) !== 1'b0) begin
          errors++;
          $display("FAIL reset_hold d%0d clk %0d: got %b want 0", depth_of(j), c, pick(j));
        end
      end
    end
  endtask

  task automatic test_latency();
    apply_reset();
    for (int k = 1; k <= 32; k++) stim[k] = (k == 1) ? 1'b1 : 1'b0;
    for (int k = 1; k <= 10; k++) begin
      sin = stim[k];
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (pick(j) !== exp_at(depth_of(j), k)) begin
          errors++;
          $display("FAIL latency d%0d edge %0d: got %b want %b", depth_of(j), k, pick(j), exp_at(depth_of(j), k));
        end
      end
    end
  endtask

  task automatic test_pattern();
    apply_reset();
    for (int k = 1; k <= 32; k++) stim[k] = (k == 3) ? 1'b0 : 1'b1;
    for (int k = 1; k <= 14; k++) begin
      sin = stim[k];
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (pick(j) !== exp_at(depth_of(j), k)) begin
          errors++;
          $display("FAIL pattern d%0d edge %0d: got %b want %b", depth_of(j), k, pick(j), exp_at(depth_of(j), k));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int k = 1; k <= 32; k++) stim[k] = 1'b0;
    stim[1] = 1'b1; stim[2] = 1'b1; stim[3] = 1'b0; stim[4] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      sin = stim[k];
      @(negedge clk);
    end
    checks++;
    if (sout4 !== 1'b1) begin
      errors++;
      $display("FAIL async_pre d4: got %b want 1", sout4);
    end
    #2;
    rst = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (pick(j) !== 1'b0) begin
        errors++;
        $display("FAIL async_clear d%0d: got %b want 0", depth_of(j), pick(j));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) stim[k] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      sin = stim[k];
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (pick(j) !== exp_at(depth_of(j), k)) begin
          errors++;
          $display("FAIL async_resume d%0d edge %0d: got %b want %b", depth_of(j), k, pick(j), exp_at(depth_of(j), k));
        end
      end
    end
  endtask

  task automatic test_hold_ones();
    apply_reset();
    for (int k = 1; k <= 32; k++) stim[k] = (k <= 8) ? 1'b1 : 1'b0;
    for (int k = 1; k <= 17; k++) begin
      sin = stim[k];
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (pick(j) !== exp_at(depth_of(j), k)) begin
          errors++;
          $display("FAIL hold_ones d%0d edge %0d: got %b want %b", depth_of(j), k, pick(j), exp_at(depth_of(j), k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_pattern();
    test_async_reset();
    test_hold_ones();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
